// File: rtl/wt_stream_reader.sv
// Dual-port weight ROM reader: fetches word pairs (even on A, odd on B) into a small
// FIFO under a slot-credit rule and streams them in address order over valid/ready.
module wt_stream_reader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 144,
  parameter int DEPTH      = 76,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr_a,
  output logic [ADDR_WIDTH-1:0] rom_addr_b,
  input  logic [DATA_WIDTH-1:0] rom_q_a,
  input  logic [DATA_WIDTH-1:0] rom_q_b,
  output logic [DATA_WIDTH-1:0] wt_data,
  output logic                  wt_valid,
  input  logic                  wt_ready,
  output logic                  wt_last,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 2;
  localparam logic [CW-1:0] LAST_W = CW'(DEPTH - 1);
  localparam logic [CW-1:0] END_W  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE_S} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, wr_ptr1, rd_ptr;
  logic [NW-1:0] count, in_flight, avail, need;
  logic [CW-1:0] iss_w, out_cnt, w;
  logic [1:0]    vld_pipe, two_pipe, wr_n;
  logic          pop, issue, two, last_beat, accept;

  assign wt_valid  = (count != '0);
  assign wt_data   = mem[rd_ptr];
  assign wt_last   = wt_valid && (out_cnt == LAST_W);
  assign pop       = wt_valid && wt_ready;
  assign last_beat = pop && wt_last;
  assign accept    = (state == IDLE) && start;
  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = (state == DONE_S);

  // A pair needs two slots, the odd tail needs one. Slots count as free once this
  // cycle's pop retires, and pairs still in the address/data pipe hold their slots.
  always_comb begin
    w         = (state == IDLE) ? '0 : iss_w;
    two       = (w != LAST_W);
    need      = two ? NW'(2) : NW'(1);
    in_flight = NW'(vld_pipe[0]) + NW'(vld_pipe[0] & two_pipe[0])
              + NW'(vld_pipe[1]) + NW'(vld_pipe[1] & two_pipe[1]);
    avail     = NW'(FIFO_DEPTH) - count + NW'(pop) - in_flight;
    issue     = accept || ((state == FETCH) && (iss_w != END_W) && (avail >= need));
    wr_n      = {vld_pipe[1] & two_pipe[1], vld_pipe[1] & ~two_pipe[1]};
    wr_ptr1   = wr_ptr + 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (last_beat) state_nx = DONE_S;
               else if (iss_w == END_W) state_nx = DRAIN;
      DRAIN:   if (last_beat) state_nx = DONE_S;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr_a <= '0;
      rom_addr_b <= '0;
      vld_pipe   <= '0;
      two_pipe   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      iss_w      <= '0;
      out_cnt    <= '0;
    end else begin
      state    <= state_nx;
      vld_pipe <= {vld_pipe[0], issue};
      two_pipe <= {two_pipe[0], two};
      if (issue) begin
        rom_addr_a <= ADDR_WIDTH'(w);
        rom_addr_b <= ADDR_WIDTH'(two ? w + 1'b1 : w);
        iss_w      <= w + CW'({two, ~two});
      end
      if (accept)   out_cnt <= '0;
      else if (pop) out_cnt <= out_cnt + 1'b1;
      wr_ptr <= wr_ptr + PW'(wr_n);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + NW'(wr_n) - NW'(pop);
    end
  end

  // Storage needs no reset; ROM data lands one cycle after its address was issued.
  always_ff @(posedge clk) begin
    if (!rst && vld_pipe[1]) begin
      mem[wr_ptr] <= rom_q_a;
      if (two_pipe[1]) mem[wr_ptr1] <= rom_q_b;
    end
  end
endmodule
